// File: rtl/wt_dcache_ship_repl.sv
// Signature-based hit prediction (SHiP) replacement for the write-through dcache:
// per-set tree-PLRU, per-line signature/reused state and a shared SHCT of saturating counters.
module wt_dcache_ship_repl #(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned NUM_SETS  = 256,
    parameter int unsigned SIG_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         hit_i,
    input  logic [$clog2(NUM_SETS)-1:0]  hit_idx_i,
    input  logic [$clog2(NUM_WAYS)-1:0]  hit_way_i,
    input  logic                         fill_i,
    input  logic [$clog2(NUM_SETS)-1:0]  fill_idx_i,
    input  logic [$clog2(NUM_WAYS)-1:0]  fill_way_i,
    input  logic [SIG_WIDTH-1:0]         fill_sig_i,
    input  logic [NUM_WAYS-1:0]          vld_i,
    output logic [$clog2(NUM_WAYS)-1:0]  victim_way_o,
    output logic                         pred_reuse_o
);

    localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
    localparam int unsigned SHCT_N = 32'd1 << SIG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = {CNT_WIDTH{1'b0}};

    logic [NUM_WAYS-2:0]  tree_r   [NUM_SETS];
    logic [SIG_WIDTH-1:0] sig_r    [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  reused_r [NUM_SETS];
    logic [CNT_WIDTH-1:0] shct_r   [SHCT_N];

    logic                 same_set_s;
    logic                 hit_tree_en_s;
    logic                 hit_reuse_en_s;
    logic                 inc_en_s;
    logic                 dec_en_s;
    logic [SIG_WIDTH-1:0] inc_sig_s;
    logic [SIG_WIDTH-1:0] dec_sig_s;
    logic [NUM_WAYS-2:0]  hit_tree_nxt_s;
    logic [NUM_WAYS-2:0]  fill_tree_nxt_s;
    logic [WAY_W-1:0]     victim_s;
    logic                 pred_s;

    // The tree is padded by one bit so node indices fit in WAY_W bits.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [NUM_WAYS-2:0] tree);
        logic [NUM_WAYS-1:0] tp;
        logic [WAY_W-1:0]    node;
        logic [WAY_W-1:0]    way;
        tp   = {1'b0, tree};
        node = '0;
        way  = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            way[l] = tp[node];
            node   = (node << 1) + WAY_W'(1'b1) + WAY_W'(tp[node]);
        end
        return way;
    endfunction

    // mru=1 points every node on the path away from the way, mru=0 toward it.
    function automatic logic [NUM_WAYS-2:0] plru_update(input logic [NUM_WAYS-2:0] tree,
                                                        input logic [WAY_W-1:0]    way,
                                                        input logic                mru);
        logic [NUM_WAYS-1:0] tp;
        logic [WAY_W-1:0]    node;
        tp   = {1'b0, tree};
        node = '0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            tp[node] = way[l] ^ mru;
            node     = (node << 1) + WAY_W'(1'b1) + WAY_W'(way[l]);
        end
        return tp[NUM_WAYS-2:0];
    endfunction

    // Update enables and next-state trees for the hit and fill ports.
    always_comb begin
        same_set_s      = hit_i & fill_i & (hit_idx_i == fill_idx_i);
        hit_tree_en_s   = hit_i & ~same_set_s;
        hit_reuse_en_s  = hit_i & ~(same_set_s & (hit_way_i == fill_way_i));
        inc_en_s        = hit_i;
        inc_sig_s       = sig_r[hit_idx_i][hit_way_i];
        dec_sig_s       = sig_r[fill_idx_i][fill_way_i];
        dec_en_s        = fill_i & vld_i[fill_way_i] & ~reused_r[fill_idx_i][fill_way_i];
        hit_tree_nxt_s  = plru_update(tree_r[hit_idx_i], hit_way_i, 1'b1);
        fill_tree_nxt_s = plru_update(tree_r[fill_idx_i], fill_way_i, pred_s);
    end

    // Victim selection: lowest invalid way first, else the PLRU leaf.
    always_comb begin
        pred_s   = (shct_r[fill_sig_i] != CNT_MIN);
        victim_s = plru_walk(tree_r[fill_idx_i]);
        for (int unsigned w = NUM_WAYS; w > 32'd0; w--) begin
            victim_s = (!vld_i[w-32'd1]) ? WAY_W'(w - 32'd1) : victim_s;
        end
    end

    assign victim_way_o = victim_s;
    assign pred_reuse_o = pred_s;

    // PLRU tree state; on a same-set collision the fill's update wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) tree_r[s] <= '0;
        end else if (flush_i) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) tree_r[s] <= '0;
        end else begin
            if (hit_tree_en_s) tree_r[hit_idx_i] <= hit_tree_nxt_s;
            if (fill_i)        tree_r[fill_idx_i] <= fill_tree_nxt_s;
        end
    end

    // Per-line signature and reused flag; a fill to the hit line clears the flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                reused_r[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) sig_r[s][w] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                reused_r[s] <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) sig_r[s][w] <= '0;
            end
        end else begin
            if (hit_reuse_en_s) reused_r[hit_idx_i][hit_way_i] <= 1'b1;
            if (fill_i) begin
                reused_r[fill_idx_i][fill_way_i] <= 1'b0;
                sig_r[fill_idx_i][fill_way_i]    <= fill_sig_i;
            end
        end
    end

    // SHCT counters survive flush; opposing updates to one entry cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SHCT_N; i++) shct_r[i] <= CNT_ONE;
        end else if (!flush_i && !(inc_en_s && dec_en_s && (inc_sig_s == dec_sig_s))) begin
            if (inc_en_s && (shct_r[inc_sig_s] != CNT_MAX)) shct_r[inc_sig_s] <= shct_r[inc_sig_s] + CNT_ONE;
            if (dec_en_s && (shct_r[dec_sig_s] != CNT_MIN)) shct_r[dec_sig_s] <= shct_r[dec_sig_s] - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_wt_dcache_ship_repl.sv
// Directed scoreboard bench for wt_dcache_ship_repl (4 ways, 256 sets, 8-bit signatures).
module tb_wt_dcache_ship_repl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       hit_i;
    logic [7:0] hit_idx_i;
    logic [1:0] hit_way_i;
    logic       fill_i;
    logic [7:0] fill_idx_i;
    logic [1:0] fill_way_i;
    logic [7:0] fill_sig_i;
    logic [3:0] vld_i;
    logic [1:0] victim_way_o;
    logic       pred_reuse_o;

    typedef struct {
        string      tag;
        bit         is_pred;
        logic [7:0] idx;
        logic [3:0] vld;
        logic [7:0] sig;
        int         exp;
    } probe_t;

    probe_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    wt_dcache_ship_repl #(
        .NUM_WAYS (4),
        .NUM_SETS (256),
        .SIG_WIDTH(8),
        .CNT_WIDTH(2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .hit_i       (hit_i),
        .hit_idx_i   (hit_idx_i),
        .hit_way_i   (hit_way_i),
        .fill_i      (fill_i),
        .fill_idx_i  (fill_idx_i),
        .fill_way_i  (fill_way_i),
        .fill_sig_i  (fill_sig_i),
        .vld_i       (vld_i),
        .victim_way_o(victim_way_o),
        .pred_reuse_o(pred_reuse_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_vic(input string tag, input int idx, input logic [3:0] vld, input int exp);
        probe_t p;
        p.tag = tag; p.is_pred = 1'b0; p.idx = 8'(idx); p.vld = vld; p.sig = 8'h00; p.exp = exp;
        sb_q.push_back(p);
    endtask

    task automatic push_pred(input string tag, input int sig, input int exp);
        probe_t p;
        p.tag = tag; p.is_pred = 1'b1; p.idx = 8'h00; p.vld = 4'hF; p.sig = 8'(sig); p.exp = exp;
        sb_q.push_back(p);
    endtask

    // Strobes are low while probing, so probes never change state.
    task automatic drain();
        probe_t p;
        while (sb_q.size() > 0) begin
            p          = sb_q.pop_front();
            fill_idx_i = p.idx;
            vld_i      = p.vld;
            fill_sig_i = p.sig;
            #1;
            if (p.is_pred) check_eq(p.tag, int'(pred_reuse_o), p.exp);
            else           check_eq(p.tag, int'(victim_way_o), p.exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        hit_i   = 1'b0;
        fill_i  = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic set_hit(input int idx, input int way);
        hit_i = 1'b1; hit_idx_i = 8'(idx); hit_way_i = 2'(way);
    endtask

    task automatic set_fill(input int idx, input int way, input int sig, input logic [3:0] vld);
        fill_i = 1'b1; fill_idx_i = 8'(idx); fill_way_i = 2'(way); fill_sig_i = 8'(sig); vld_i = vld;
    endtask

    task automatic do_hit(input int idx, input int way);
        set_hit(idx, way);
        cycle();
    endtask

    task automatic do_fill(input int idx, input int way, input int sig, input logic [3:0] vld);
        set_fill(idx, way, sig, vld);
        cycle();
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; hit_i = 1'b0; fill_i = 1'b0;
        hit_idx_i = 8'h00; hit_way_i = 2'd0; fill_idx_i = 8'h00; fill_way_i = 2'd0;
        fill_sig_i = 8'h00; vld_i = 4'hF;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        push_vic("rst_vic", 0, 4'hF, 0);
        push_pred("rst_pred_00", 8'h00, 1);
        push_pred("rst_pred_ab", 8'hAB, 1);
        drain();

        // Tree walk (SHCT[0] goes 1 -> 3 through these hits on sig-0 lines)
        do_hit(5, 0);
        push_vic("walk_h0", 5, 4'hF, 2);
        drain();
        do_hit(5, 2);
        push_vic("walk_h2", 5, 4'hF, 1);
        push_vic("walk_s6", 6, 4'hF, 0);
        drain();

        push_vic("inv_1011", 5, 4'b1011, 2);
        push_vic("inv_0000", 5, 4'b0000, 0);
        push_vic("inv_0111", 5, 4'b0111, 3);
        drain();

        // Distant insertion after an unreused eviction
        do_fill(9, 3, 8'h21, 4'h0);
        push_vic("dist_mru", 9, 4'hF, 0);
        push_pred("dist_pred1", 8'h21, 1);
        drain();
        do_fill(9, 3, 8'h55, 4'hF);
        push_pred("dist_dec", 8'h21, 0);
        drain();
        do_fill(9, 1, 8'h21, 4'hF);
        push_vic("dist_lru", 9, 4'hF, 1);
        drain();

        // Saturation at the top, then decrements down to and past zero
        do_fill(20, 0, 8'h40, 4'h0);
        repeat (4) do_hit(20, 0);
        push_pred("sat_inc", 8'h40, 1);
        drain();
        for (int k = 0; k < 4; k++) begin
            do_fill(21, 0, 8'h40, 4'h0);
            do_fill(21, 0, 8'h41, 4'hF);
            push_pred($sformatf("sat_dec%0d", k), 8'h40, (k < 2) ? 1 : 0);
            drain();
        end

        // Same-set hit and fill: only the fill moves the tree
        do_fill(3, 0, 8'h30, 4'h0);
        push_vic("col_pre", 3, 4'hF, 2);
        drain();
        set_hit(3, 0);
        set_fill(3, 3, 8'h77, 4'h0);
        cycle();
        push_vic("col_tree", 3, 4'hF, 1);
        drain();

        // Opposing SHCT updates on one entry cancel
        do_fill(40, 0, 8'h60, 4'h0);
        do_fill(41, 0, 8'h60, 4'h0);
        set_hit(40, 0);
        set_fill(41, 0, 8'h61, 4'hF);
        cycle();
        push_pred("incdec_same", 8'h60, 1);
        drain();
        do_fill(42, 0, 8'h60, 4'h0);
        do_fill(42, 0, 8'h62, 4'hF);
        push_pred("incdec_after", 8'h60, 0);
        drain();

        // Bring SHCT[0] from 2 to 0, then mark one sig-0 line reused (SHCT[0] = 1)
        do_fill(70, 0, 8'h70, 4'hF);
        do_fill(70, 1, 8'h70, 4'hF);
        push_pred("fl_sig0_zero", 8'h00, 0);
        drain();
        do_hit(60, 2);
        push_pred("fl_sig0_one", 8'h00, 1);
        drain();

        // Flush with a simultaneous hit that must be ignored
        set_hit(5, 0);
        flush_i = 1'b1;
        cycle();
        push_vic("fl_vic5", 5, 4'hF, 0);
        push_vic("fl_vic9", 9, 4'hF, 0);
        push_vic("fl_vic3", 3, 4'hF, 0);
        push_pred("fl_keep_21", 8'h21, 0);
        push_pred("fl_keep_30", 8'h30, 1);
        push_pred("fl_keep_40", 8'h40, 0);
        push_pred("fl_keep_00", 8'h00, 1);
        drain();
        do_fill(60, 2, 8'h99, 4'hF);
        push_pred("fl_reused_clr", 8'h00, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wt_dcache_ship_repl.md
WT_DCACHE_SHIP_REPL -- requirements
Module: wt_dcache_ship_repl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4: associativity; power of two, at least 2.
REQ-002 SHALL have parameter NUM_SETS, default 256: number of sets; power of two.
REQ-003 SHALL have parameter SIG_WIDTH, default 8: signature width; the SHCT has 2^SIG_WIDTH entries, indexed directly by the signature.
REQ-004 SHALL have parameter CNT_WIDTH, default 2: SHCT saturating-counter width.
REQ-005 Port list (name, direction, width, meaning):
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- flush_i, in, 1: synchronous flush.
- hit_i, in, 1: hit update strobe.
- hit_idx_i, in, log2(NUM_SETS): set index of the hit.
- hit_way_i, in, log2(NUM_WAYS): way that hit.
- fill_i, in, 1: line-fill strobe.
- fill_idx_i, in, log2(NUM_SETS): set index of the fill.
- fill_way_i, in, log2(NUM_WAYS): way being filled.
- fill_sig_i, in, SIG_WIDTH: signature of the incoming line.
- vld_i, in, NUM_WAYS: valid bits of set fill_idx_i.
- victim_way_o, out, log2(NUM_WAYS): replacement way for fill_idx_i.
- pred_reuse_o, out, 1: reuse prediction for fill_sig_i.

Function
REQ-006 Per set, SHALL hold a tree-PLRU of NUM_WAYS-1 bits in heap order: root is node 0, children of node n are 2n+1 and 2n+2. A bit value of 0 points to the lower-way subtree.
REQ-007 Per line, SHALL hold a SIG_WIDTH signature and a 1-bit reused flag.
REQ-008 SHALL hold 2^SIG_WIDTH saturating counters of CNT_WIDTH bits (the SHCT).
REQ-009 victim_way_o SHALL be combinational and SHALL be the lowest-numbered way with vld_i low, if any such way exists.
REQ-010 Otherwise, victim_way_o SHALL be the leaf reached by walking the fill_idx_i tree from the root, following the bit at each node.
REQ-011 pred_reuse_o SHALL be combinational and SHALL be 1 when SHCT[fill_sig_i] is non-zero.
REQ-012 On hit_i, the next cycle SHALL promote hit_way_i to MRU: every node on its path points away from it.
REQ-013 On hit_i, the next cycle SHALL set the line's reused flag, and SHALL increment SHCT[stored signature], saturating at 2^CNT_WIDTH-1.
REQ-014 On fill_i with pred_reuse_o=1, the next cycle SHALL insert fill_way_i as MRU (path bits point away from it).
REQ-015 On fill_i with pred_reuse_o=0, the next cycle SHALL insert fill_way_i as LRU (path bits point toward it).
REQ-016 On fill_i, the next cycle SHALL store fill_sig_i in the filled line and clear its reused flag.
REQ-017 On fill_i where vld_i[fill_way_i]=1 and the evicted line's reused flag is 0, SHALL decrement SHCT[evicted signature], saturating at 0.
REQ-018 A hit and a fill to the same set in the same cycle SHALL apply the fill's tree update only; the hit's reused-flag update SHALL still apply unless hit_way_i equals fill_way_i.
REQ-019 Hits and fills to different sets in the same cycle SHALL both take full effect.
REQ-020 When an increment and a decrement target the same SHCT entry in the same cycle, that counter SHALL remain unchanged.
REQ-021 Update latency SHALL be exactly one cycle; there SHALL be no stall and no backpressure.
REQ-022 flush_i SHALL clear all tree bits, signatures and reused flags on the next edge, SHALL retain the SHCT, and SHALL override a simultaneous hit_i or fill_i.
REQ-023 The block SHALL be fully synchronous except rst_ni, and SHALL have no combinational path from hit_* inputs to either output.

Reset
REQ-024 rst_ni low SHALL asynchronously clear all tree bits, signatures and reused flags.
REQ-025 rst_ni low SHALL set every SHCT counter to 1 (weak reuse).
REQ-026 After reset with vld_i all ones, victim_way_o SHALL be 0 and pred_reuse_o SHALL be 1.
REQ-027 rst_ni asserted mid-update SHALL discard that update.

Verification (NUM_WAYS=4, NUM_SETS=256, SIG_WIDTH=8, CNT_WIDTH=2)
REQ-028 Tree walk: reset, vld_i=4'hF; hit set 5 way 0 -> victim for set 5 is 2; then hit way 2 -> victim is 1; set 6 victim stays 0.
REQ-029 Invalid priority: vld_i=4'b1011 -> victim 2 regardless of tree; vld_i=4'b0000 -> victim 0.
REQ-030 Distant-insertion path: fill set 9 way 3 with sig 0x21; later evict it unreused -> SHCT[0x21]=0, pred_reuse_o=0 for 0x21; next fill set 9 way 1 with 0x21 -> victim for set 9 is 1 next cycle.
REQ-031 Saturation: four hits on a line with sig 0x40 -> SHCT[0x40]=3 and does not wrap; decrement at 0 stays 0.
REQ-032 Collision: same-cycle hit and fill to set 3 -> tree reflects the fill only. Increment and decrement to the same SHCT entry in one cycle -> counter unchanged.
REQ-033 Flush: after traffic, pulse flush_i -> all victims 0 and reused flags clear; SHCT values preserved; a hit in the flush cycle is ignored.
